ball_controller: RTL and testbench

//  Ball physics for pong: moves the ball once per timing_tick, bounces off top/bottom walls and paddles,
//  and lets a missed ball run into the goal zone, holds it there, then re-serves from centre.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/ball_controller.sv | 173 +++++++++++++++++
 tb/tb_ball_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display/game constants for the pong datapath.
// Game-state encoding consumed by ball, score and renderer blocks; screen and
// paddle geometry in pixels.
package vga_pkg;

  // Game state encoding (2-bit state bus)
  localparam logic [1:0] menu_start = 2'd0;
  localparam logic [1:0] game_play  = 2'd1;
  localparam logic [1:0] game_pause = 2'd2;
  localparam logic [1:0] game_end   = 2'd3;

  // Screen and object geometry, px
  localparam int SCREEN_W  = 1024;
  localparam int SCREEN_H  = 768;
  localparam int BALL_SIZE = 15;
  localparam int X_PAD_L   = 30;   // first px right of the left paddle
  localparam int X_PAD_R   = 979;  // first px of the right paddle
  localparam int PAD_H     = 120;

endpackage

// File: rtl/ball_controller.sv
// Ball physics for pong: serve from centre, per-tick motion, wall and paddle
// bounces, goal-zone hold after a miss, then re-serve.
// Ports: clk/rst (sync, active-high); timing_tick frame strobe; state game mode;
//   y_pad_left/right paddle tops; x_ball/y_ball registered top-left corner;
//   paddle_hit / ball_out single-cycle pulses aligned with the position update.
module ball_controller
  import vga_pkg::*;
#(
  parameter int SPEED_X0    = 4,
  parameter int SPEED_XMAX  = 10,
  parameter int SPEED_Y     = 3,
  parameter int SERVE_TICKS = 60,
  parameter int HOLD_TICKS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [1:0]  state,
  input  logic [10:0] y_pad_left,
  input  logic [10:0] y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic        paddle_hit,
  output logic        ball_out
);

  typedef enum logic [1:0] {SERVE, MOVE, OUT} ball_fsm_t;

  localparam logic [10:0] X_C    = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] Y_C    = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_L    = 11'(X_PAD_L);
  localparam logic [10:0] X_R    = 11'(X_PAD_R - BALL_SIZE);
  localparam logic signed [11:0] X_MAX_S = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX_S = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] X_L_S   = 12'(X_PAD_L);
  localparam logic signed [11:0] X_R_S   = 12'(X_PAD_R - BALL_SIZE);
  localparam logic signed [11:0] VY_S    = 12'(SPEED_Y);
  localparam logic [11:0] BALL_12    = 12'(BALL_SIZE);
  localparam logic [11:0] PAD_H_12   = 12'(PAD_H);
  localparam logic [3:0]  VX0        = 4'(SPEED_X0);
  localparam logic [3:0]  VXMAX      = 4'(SPEED_XMAX);
  localparam logic [5:0]  SERVE_LAST = 6'(SERVE_TICKS - 1);
  localparam logic [5:0]  HOLD_LAST  = 6'(HOLD_TICKS - 1);

  ball_fsm_t   fsm, fsm_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [3:0]  vx, vx_nx;
  logic        dir_x_pos, dir_x_nx;   // 1: moving right
  logic        dir_y_pos, dir_y_nx;   // 1: moving down
  logic [10:0] x_nx, y_nx;
  logic        hit_nx, out_nx;

  logic signed [11:0] px, py, pnx, pny;
  logic        ov_l, ov_r, restart, run;

  assign restart = rst || (state == menu_start) || (state == game_end);
  assign run     = (state == game_play) && timing_tick;

  // 12-bit signed candidates so a step past either edge shows up as a
  // negative / oversize value instead of wrapping.
  assign px  = $signed({1'b0, x_ball});
  assign py  = $signed({1'b0, y_ball});
  assign pnx = dir_x_pos ? px + $signed({8'd0, vx}) : px - $signed({8'd0, vx});
  assign pny = dir_y_pos ? py + VY_S : py - VY_S;

  // Paddle overlap uses the current (pre-step) vertical position.
  assign ov_l = (({1'b0, y_ball} + BALL_12) > {1'b0, y_pad_left}) &&
                ({1'b0, y_ball} < ({1'b0, y_pad_left} + PAD_H_12));
  assign ov_r = (({1'b0, y_ball} + BALL_12) > {1'b0, y_pad_right}) &&
                ({1'b0, y_ball} < ({1'b0, y_pad_right} + PAD_H_12));

  always_comb begin
    fsm_nx   = fsm;
    cnt_nx   = cnt;
    vx_nx    = vx;
    dir_x_nx = dir_x_pos;
    dir_y_nx = dir_y_pos;
    x_nx     = x_ball;
    y_nx     = y_ball;
    hit_nx   = 1'b0;
    out_nx   = 1'b0;
    if (run) begin
      case (fsm)
        SERVE: begin
          x_nx = X_C;
          y_nx = Y_C;
          if (cnt == SERVE_LAST) begin
            fsm_nx = MOVE;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 6'd1;
          end
        end
        MOVE: begin
          // Vertical and horizontal resolve independently (corner bounces).
          if (pny < 12'sd0) begin
            y_nx     = '0;
            dir_y_nx = ~dir_y_pos;
          end else if (pny > Y_MAX_S) begin
            y_nx     = Y_MAX;
            dir_y_nx = ~dir_y_pos;
          end else begin
            y_nx = pny[10:0];
          end
          // Paddle test only when this step crosses a paddle face; once past
          // the face the ball runs on into the goal zone.
          if (!dir_x_pos && (px >= X_L_S) && (pnx < X_L_S) && ov_l) begin
            x_nx     = X_L;
            dir_x_nx = 1'b1;
            hit_nx   = 1'b1;
          end else if (dir_x_pos && (px <= X_R_S) && (pnx > X_R_S) && ov_r) begin
            x_nx     = X_R;
            dir_x_nx = 1'b0;
            hit_nx   = 1'b1;
          end else if (pnx <= 12'sd0) begin
            x_nx   = '0;
            fsm_nx = OUT;
            out_nx = 1'b1;
          end else if (pnx >= X_MAX_S) begin
            x_nx   = X_MAX;
            fsm_nx = OUT;
            out_nx = 1'b1;
          end else begin
            x_nx = pnx[10:0];
          end
          if (hit_nx) vx_nx = (vx >= VXMAX) ? VXMAX : vx + 4'd1;
        end
        OUT: begin
          // Ball parks at the edge so the scorer sees it in the goal zone.
          if (cnt == HOLD_LAST) begin
            x_nx     = X_C;
            y_nx     = Y_C;
            vx_nx    = VX0;
            dir_x_nx = (x_ball == 11'd0);  // serve away from the edge it hit
            dir_y_nx = ~dir_y_pos;
            cnt_nx   = '0;
            fsm_nx   = SERVE;
          end else begin
            cnt_nx = cnt + 6'd1;
          end
        end
        default: fsm_nx = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      fsm        <= SERVE;
      cnt        <= '0;
      vx         <= VX0;
      dir_x_pos  <= 1'b1;
      dir_y_pos  <= 1'b1;
      x_ball     <= X_C;
      y_ball     <= Y_C;
      paddle_hit <= 1'b0;
      ball_out   <= 1'b0;
    end else begin
      fsm        <= fsm_nx;
      cnt        <= cnt_nx;
      vx         <= vx_nx;
      dir_x_pos  <= dir_x_nx;
      dir_y_pos  <= dir_y_nx;
      x_ball     <= x_nx;
      y_ball     <= y_nx;
      paddle_hit <= hit_nx;
      ball_out   <= out_nx;
    end
  end

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: serve timing, pause freeze, paddle hit and
// speed-up, top/bottom walls, right-side miss with hold and re-serve, restart.
module tb_ball_controller;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic [1:0]  state;
  logic [10:0] y_pad_left;
  logic [10:0] y_pad_right;
  logic [10:0] x_ball;
  logic [10:0] y_ball;
  logic        paddle_hit;
  logic        ball_out;

  int n_cmp = 0;
  int n_err = 0;

  ball_controller dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .state       (state),
    .y_pad_left  (y_pad_left),
    .y_pad_right (y_pad_right),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .paddle_hit  (paddle_hit),
    .ball_out    (ball_out)
  );

  always #5 clk = ~clk;

  // One tick cycle; returns on the falling edge after the updating rising edge.
  task automatic do_tick();
    @(negedge clk) timing_tick = 1'b1;
    @(negedge clk) timing_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_xy(input string tag, input int ex, input int ey);
    chk({tag, ".x"}, int'(x_ball), ex);
    chk({tag, ".y"}, int'(y_ball), ey);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; state = menu_start; timing_tick = 1'b0;
    y_pad_left = 11'd200; y_pad_right = 11'd640;
    repeat (3) @(negedge clk);
    chk_xy("reset", 504, 376);
    chk("reset.hit", int'(paddle_hit), 0);
    chk("reset.out", int'(ball_out), 0);

    // Serve: 60 ticks at centre, with a pause in the middle that must not
    // advance the serve counter.
    rst = 1'b0; state = game_play;
    @(negedge clk);
    ticks(30);
    chk_xy("serve30", 504, 376);
    state = game_pause;
    ticks(100);
    chk_xy("serve_pause", 504, 376);
    state = game_play;
    ticks(29);
    chk_xy("serve59", 504, 376);
    do_tick();
    chk_xy("serve60", 504, 376);
    do_tick();
    chk_xy("move1", 508, 379);

    // Pause mid-flight, then resume on the same trajectory.
    ticks(9);
    chk_xy("move10", 544, 406);
    state = game_pause;
    ticks(100);
    chk_xy("flight_pause", 544, 406);
    state = game_play;
    do_tick();
    chk_xy("move11", 548, 409);

    // Right paddle hit (pad top 640 covers y=721).
    ticks(104);
    chk_xy("move115", 964, 721);
    chk("pre_hit", int'(paddle_hit), 0);
    do_tick();
    chk_xy("rhit", 964, 724);
    chk("rhit.pulse", int'(paddle_hit), 1);
    @(negedge clk);
    chk("rhit.clear", int'(paddle_hit), 0);
    do_tick();
    chk_xy("vx5", 959, 727);

    // Bottom wall: y 751 moving down clamps to 753 and reverses.
    ticks(8);
    chk_xy("pre_bot", 919, 751);
    do_tick();
    chk_xy("bot_wall", 914, 753);
    do_tick();
    chk_xy("bot_rev", 909, 750);

    // Left paddle hit (pad top 200 covers y=225), speed to 6.
    ticks(175);
    chk_xy("pre_lhit", 34, 225);
    do_tick();
    chk_xy("lhit", 30, 222);
    chk("lhit.pulse", int'(paddle_hit), 1);
    do_tick();
    chk_xy("vx6", 36, 219);

    // Top wall: lands exactly on 0, then the next step reverses at 0.
    ticks(73);
    chk_xy("top_zero", 474, 0);
    do_tick();
    chk_xy("top_wall", 480, 0);
    do_tick();
    chk_xy("top_rev", 486, 3);

    // Right miss: paddle moved away, ball runs into goal and clamps at 1009.
    ticks(79);
    chk_xy("pre_miss", 960, 240);
    y_pad_right = 11'd0;
    do_tick();
    chk_xy("miss", 966, 243);
    chk("miss.nohit", int'(paddle_hit), 0);
    do_tick();
    chk_xy("past_face", 972, 246);
    ticks(6);
    chk_xy("pre_out", 1008, 264);
    chk("pre_out.pulse", int'(ball_out), 0);
    do_tick();
    chk_xy("out", 1009, 267);
    chk("out.pulse", int'(ball_out), 1);
    @(negedge clk);
    chk("out.clear", int'(ball_out), 0);

    // Hold for 30 ticks, then re-serve heading left and up.
    ticks(29);
    chk_xy("hold29", 1009, 267);
    do_tick();
    chk_xy("respawn", 504, 376);
    ticks(59);
    chk_xy("reserve59", 504, 376);
    do_tick();
    chk_xy("reserve60", 504, 376);
    do_tick();
    chk_xy("serve_left", 500, 373);
    do_tick();
    chk_xy("serve_left2", 496, 370);

    // menu_start mid-flight restarts the serve with default direction.
    state = menu_start;
    @(negedge clk);
    chk_xy("menu", 504, 376);
    chk("menu.hit", int'(paddle_hit), 0);
    chk("menu.out", int'(ball_out), 0);
    state = game_play;
    ticks(60);
    chk_xy("menu_serve", 504, 376);
    do_tick();
    chk_xy("menu_move1", 508, 379);

    // Second right miss (pad top 0), then reset while held in the goal zone.
    ticks(114);
    chk_xy("m2_115", 964, 721);
    do_tick();
    chk_xy("m2_miss", 968, 724);
    ticks(10);
    chk_xy("m2_126", 1008, 753);
    do_tick();
    chk_xy("m2_out", 1009, 750);
    chk("m2_out.pulse", int'(ball_out), 1);
    ticks(5);
    chk_xy("m2_hold", 1009, 750);
    rst = 1'b1;
    @(negedge clk);
    chk_xy("rst_out", 504, 376);
    chk("rst_out.hit", int'(paddle_hit), 0);
    chk("rst_out.out", int'(ball_out), 0);
    rst = 1'b0;
    ticks(60);
    chk_xy("rst_serve", 504, 376);
    do_tick();
    chk_xy("rst_move1", 508, 379);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
